// File: rtl/plugboard_prog_if.sv
// rtl/plugboard_prog_if.sv - Letter stream and config request bundle for the programmable plugboard
interface plugboard_prog_if #(
   parameter int N_LETTERS = 26,
   parameter int IDX_W     = 5,
   parameter int PC_W      = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [N_LETTERS-1:0] in_letter;
   logic                 out_valid;
   logic [N_LETTERS-1:0] out_letter;
   logic                 out_bad;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [1:0]           cfg_op;
   logic [IDX_W-1:0]     cfg_a;
   logic [IDX_W-1:0]     cfg_b;
   logic                 cfg_done;
   logic                 cfg_err;
   logic [PC_W-1:0]      pair_count;

   modport master (
      output in_valid, in_letter, cfg_valid, cfg_op, cfg_a, cfg_b,
      input  in_ready, out_valid, out_letter, out_bad, cfg_ready, cfg_done, cfg_err, pair_count
   );

   modport slave (
      input  in_valid, in_letter, cfg_valid, cfg_op, cfg_a, cfg_b,
      output in_ready, out_valid, out_letter, out_bad, cfg_ready, cfg_done, cfg_err, pair_count
   );
endinterface

// File: rtl/plugboard_prog.sv
// rtl/plugboard_prog.sv - Programmable Enigma plugboard: registered one-hot swap through a runtime pair table
module plugboard_prog #(
   parameter int N_LETTERS = 26,
   parameter int MAX_PAIRS = 10,
   parameter int IDX_W     = 5,
   parameter int PC_W      = $clog2(MAX_PAIRS + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   plugboard_prog_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_CLEAR} state_t;

   localparam logic [1:0]       OP_ADD    = 2'd0;
   localparam logic [1:0]       OP_REMOVE = 2'd1;
   localparam logic [1:0]       OP_CLEAR  = 2'd2;
   localparam logic [IDX_W-1:0] LAST      = IDX_W'(N_LETTERS - 1);
   localparam logic [PC_W-1:0]  PC_MAX    = PC_W'(MAX_PAIRS);

   state_t               state, state_n;
   logic [IDX_W-1:0]     map [N_LETTERS];
   logic [1:0]           op_q;
   logic [IDX_W-1:0]     a_q, b_q, ptr;
   logic [PC_W-1:0]      count;
   logic                 done_q, err_q;
   logic                 out_valid_q, out_bad_q;
   logic [N_LETTERS-1:0] out_letter_q;

   logic                 in_ready_w, cfg_ready_w, cfg_fire, in_fire, one_hot;
   logic [IDX_W-1:0]     in_idx, lut, map_a, map_b;
   logic [N_LETTERS-1:0] lut_onehot;
   logic                 a_in, b_in, add_ok, rm_ok;
   logic                 do_add, do_rm, done_n, err_n;

   assign in_ready_w  = (state != S_CLEAR);
   assign cfg_ready_w = (state == S_IDLE);
   assign cfg_fire    = cfg_ready_w && bus.cfg_valid;
   assign in_fire     = in_ready_w && bus.in_valid;
   assign one_hot     = (bus.in_letter != '0) &&
                        ((bus.in_letter & (bus.in_letter - N_LETTERS'(1))) == '0);

   // Lookup reads the registered table, so a letter accepted on a commit edge sees the old mapping
   always_comb begin
      in_idx     = '0;
      lut_onehot = '0;
      for (int i = 0; i < N_LETTERS; i++)
         if (bus.in_letter[i]) in_idx = IDX_W'(i);
      lut = map[in_idx];
      for (int j = 0; j < N_LETTERS; j++)
         lut_onehot[j] = (lut == IDX_W'(j));
   end

   always_comb begin
      a_in   = (int'(a_q) < N_LETTERS);
      b_in   = (int'(b_q) < N_LETTERS);
      map_a  = map[a_q];
      map_b  = map[b_q];
      add_ok = a_in && b_in && (a_q != b_q) && (map_a == a_q) && (map_b == b_q) && (count != PC_MAX);
      rm_ok  = a_in && (map_a != a_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      do_add  = 1'b0;
      do_rm   = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.cfg_valid) state_n = (bus.cfg_op == OP_CLEAR) ? S_CLEAR : S_CHECK;
         end
         S_CHECK: begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            if (op_q == OP_ADD && add_ok)         do_add = 1'b1;
            else if (op_q == OP_REMOVE && rm_ok)  do_rm  = 1'b1;
            else                                  err_n  = 1'b1;
         end
         S_CLEAR: begin
            if (ptr == LAST) begin
               state_n = S_IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_LETTERS; i++) map[i] <= IDX_W'(i);
         op_q   <= OP_ADD;
         a_q    <= '0;
         b_q    <= '0;
         ptr    <= '0;
         count  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= done_n;
         err_q  <= err_n;
         if (cfg_fire) begin
            op_q <= bus.cfg_op;
            a_q  <= bus.cfg_a;
            b_q  <= bus.cfg_b;
            ptr  <= '0;
         end
         if (do_add) begin
            map[a_q] <= b_q;
            map[b_q] <= a_q;
            count    <= count + PC_W'(1);
         end
         if (do_rm) begin
            map[a_q]   <= a_q;
            map[map_a] <= map_a;
            count      <= count - PC_W'(1);
         end
         if (state == S_CLEAR) begin
            map[ptr] <= ptr;
            ptr      <= ptr + IDX_W'(1);
            if (ptr == LAST) count <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_bad_q    <= 1'b0;
         out_letter_q <= '0;
      end else begin
         out_valid_q  <= in_fire;
         out_bad_q    <= in_fire && !one_hot;
         out_letter_q <= (in_fire && one_hot) ? lut_onehot : '0;
      end
   end

   assign bus.in_ready   = in_ready_w;
   assign bus.cfg_ready  = cfg_ready_w;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_letter = out_letter_q;
   assign bus.out_bad    = out_bad_q;
   assign bus.cfg_done   = done_q;
   assign bus.cfg_err    = err_q;
   assign bus.pair_count = count;
endmodule

// File: tb/tb_plugboard_prog.sv
// tb/tb_plugboard_prog.sv - Vector-table and scoreboard bench for the programmable plugboard
`timescale 1ns/1ps
module tb_plugboard_prog;
   localparam int NL = 26;
   localparam int NV = 25;
   localparam logic [1:0] OP_ADD = 2'd0, OP_REM = 2'd1, OP_CLR = 2'd2, OP_RSV = 2'd3;

   typedef struct { logic [1:0] op; int a; int b; logic err; int cnt; } cfg_vec_t;
   typedef struct { logic [NL-1:0] letter; logic bad; int cyc; } exp_t;

   logic     clk = 1'b0;
   logic     rst_n = 1'b0;
   int       checks = 0;
   int       errors = 0;
   int       cyc = 0;
   int       m [NL];
   exp_t     sb [$];
   cfg_vec_t vecs [NV];

   plugboard_prog_if #(.N_LETTERS(NL), .IDX_W(5), .PC_W(4)) bus ();

   plugboard_prog #(.N_LETTERS(NL), .MAX_PAIRS(10), .IDX_W(5), .PC_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (bus.out_valid) begin
            if (sb.size() == 0) chk("out_valid_unexpected", int'(bus.out_valid), 0);
            else begin
               e = sb.pop_front();
               chk("out_letter", int'(bus.out_letter), int'(e.letter));
               chk("out_bad", int'(bus.out_bad), int'(e.bad));
               chk("out_latency", cyc, e.cyc + 1);
            end
         end
         if (bus.cfg_err) chk("err_without_done", int'(bus.cfg_done), 1);
      end
   end

   task automatic push_exp(input logic [NL-1:0] l, input logic bad);
      exp_t e;
      e.letter = l;
      e.bad    = bad;
      e.cyc    = cyc;
      sb.push_back(e);
   endtask

   task automatic model_identity();
      for (int i = 0; i < NL; i++) m[i] = i;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_out_valid"},  int'(bus.out_valid), 0);
      chk({tag, "_out_letter"}, int'(bus.out_letter), 0);
      chk({tag, "_out_bad"},    int'(bus.out_bad), 0);
      chk({tag, "_cfg_done"},   int'(bus.cfg_done), 0);
      chk({tag, "_cfg_err"},    int'(bus.cfg_err), 0);
      chk({tag, "_cfg_ready"},  int'(bus.cfg_ready), 1);
      chk({tag, "_in_ready"},   int'(bus.in_ready), 1);
      chk({tag, "_pair_count"}, int'(bus.pair_count), 0);
   endtask

   // Every letter back to back; expectations come from the bench's own pair model
   task automatic send_all();
      logic [NL-1:0] l, x;
      for (int i = 0; i < NL; i++) begin
         l = '0; l[i] = 1'b1;
         x = '0; x[m[i]] = 1'b1;
         bus.in_valid  = 1'b1;
         bus.in_letter = l;
         push_exp(x, 1'b0);
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.in_letter = '0;
      @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      sb.delete();
   endtask

   task automatic do_cfg(input cfg_vec_t v);
      int lat;
      int p;
      bus.cfg_valid = 1'b1;
      bus.cfg_op    = v.op;
      bus.cfg_a     = 5'(v.a);
      bus.cfg_b     = 5'(v.b);
      chk("cfg_ready", int'(bus.cfg_ready), 1);
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         if (bus.cfg_done) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      chk("cfg_latency", lat, 2);
      chk("cfg_err", int'(bus.cfg_err), int'(v.err));
      chk("pair_count", int'(bus.pair_count), v.cnt);
      if (!v.err) begin
         if (v.op == OP_ADD) begin
            m[v.a] = v.b;
            m[v.b] = v.a;
         end else if (v.op == OP_REM) begin
            p = m[v.a];
            m[v.a] = v.a;
            m[p] = p;
         end
      end
      @(negedge clk);
      chk("cfg_done_pulse", int'(bus.cfg_done), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, busy, seen;
      bus.in_valid  = 1'b0;
      bus.in_letter = '0;
      bus.cfg_valid = 1'b0;
      bus.cfg_op    = 2'd0;
      bus.cfg_a     = '0;
      bus.cfg_b     = '0;
      model_identity();

      vecs[0]  = '{OP_ADD, 0, 1, 1'b0, 1};
      vecs[1]  = '{OP_ADD, 4, 25, 1'b0, 2};
      vecs[2]  = '{OP_ADD, 1, 2, 1'b1, 2};
      vecs[3]  = '{OP_ADD, 3, 3, 1'b1, 2};
      vecs[4]  = '{OP_ADD, 26, 0, 1'b1, 2};
      vecs[5]  = '{OP_ADD, 0, 5, 1'b1, 2};
      vecs[6]  = '{OP_ADD, 2, 3, 1'b0, 3};
      vecs[7]  = '{OP_ADD, 5, 6, 1'b0, 4};
      vecs[8]  = '{OP_ADD, 7, 8, 1'b0, 5};
      vecs[9]  = '{OP_ADD, 9, 10, 1'b0, 6};
      vecs[10] = '{OP_ADD, 11, 12, 1'b0, 7};
      vecs[11] = '{OP_ADD, 13, 14, 1'b0, 8};
      vecs[12] = '{OP_ADD, 15, 16, 1'b0, 9};
      vecs[13] = '{OP_ADD, 17, 18, 1'b0, 10};
      vecs[14] = '{OP_ADD, 19, 20, 1'b1, 10};
      vecs[15] = '{OP_REM, 7, 0, 1'b0, 9};
      vecs[16] = '{OP_REM, 7, 0, 1'b1, 9};
      vecs[17] = '{OP_REM, 19, 0, 1'b1, 9};
      vecs[18] = '{OP_REM, 30, 0, 1'b1, 9};
      vecs[19] = '{OP_RSV, 0, 0, 1'b1, 9};
      vecs[20] = '{OP_ADD, 19, 20, 1'b0, 10};
      vecs[21] = '{OP_REM, 25, 0, 1'b0, 9};
      vecs[22] = '{OP_ADD, 5, 31, 1'b1, 9};
      vecs[23] = '{OP_ADD, 24, 25, 1'b0, 10};
      vecs[24] = '{OP_ADD, 21, 22, 1'b1, 10};

      repeat (3) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);
      send_all();

      for (int v = 0; v < NV; v++) begin
         do_cfg(vecs[v]);
         send_all();
      end

      // CLEAR with a letter held valid for the whole sweep
      bus.cfg_valid = 1'b1;
      bus.cfg_op    = OP_CLR;
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_letter = 26'h1;
      lat  = 0;
      busy = 0;
      for (int k = 1; k <= 40; k++) begin
         if (bus.cfg_done) begin
            lat = k;
            break;
         end
         if (!bus.in_ready) busy++;
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.in_letter = '0;
      chk("clear_latency", lat, NL + 1);
      chk("clear_busy_cycles", busy, NL);
      chk("clear_err", int'(bus.cfg_err), 0);
      chk("clear_pair_count", int'(bus.pair_count), 0);
      model_identity();
      @(negedge clk);
      chk("clear_done_pulse", int'(bus.cfg_done), 0);
      send_all();

      // Letter accepted on the ADD commit edge sees the old table, the next one the new
      bus.cfg_valid = 1'b1;
      bus.cfg_op    = OP_ADD;
      bus.cfg_a     = 5'd2;
      bus.cfg_b     = 5'd3;
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_letter = 26'h4;
      push_exp(26'h4, 1'b0);
      @(negedge clk);
      chk("commit_done", int'(bus.cfg_done), 1);
      bus.in_letter = 26'h4;
      push_exp(26'h8, 1'b0);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.in_letter = '0;
      m[2] = 3;
      m[3] = 2;
      @(negedge clk);
      chk("commit_pair_count", int'(bus.pair_count), 1);
      chk("commit_drained", sb.size(), 0);

      // Non-one-hot inputs
      bus.in_valid  = 1'b1;
      bus.in_letter = '0;
      push_exp('0, 1'b1);
      @(negedge clk);
      bus.in_letter = 26'h9;
      push_exp('0, 1'b1);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.in_letter = '0;
      @(negedge clk);
      chk("bad_drained", sb.size(), 0);

      // Reset early in a CLEAR, before the sweep reaches the installed pair
      bus.cfg_valid = 1'b1;
      bus.cfg_op    = OP_CLR;
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset("midclear");
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.cfg_done) seen++;
      end
      chk("no_done_after_reset", seen, 0);
      chk("midclear_in_ready", int'(bus.in_ready), 1);
      model_identity();
      send_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
